// File: rtl/calc_pkg.sv
// Shared types and constants for the four-port calculator.
// Bit 31 of every data bus here is the externally numbered bit 0 (the MSB).
package calc_pkg;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int RESP_W    = 2;
  localparam int SHAMT_W   = 5;
  localparam int NUM_PORTS = 4;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } state_e;

endpackage

// File: rtl/calc_if.sv
// Requester/response bundle for the four calculator ports.
interface calc_if;
  import calc_pkg::*;

  logic [CMD_W-1:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  data_t             req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [RESP_W-1:0] out_resp1, out_resp2, out_resp3, out_resp4;
  data_t             out_data1, out_data2, out_data3, out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational unsigned ALU for one calculator port.
module calc_alu
  import calc_pkg::*;
(
  input  logic [CMD_W-1:0]  cmd,
  input  data_t             op1,
  input  data_t             op2,
  output logic [RESP_W-1:0] resp,
  output data_t             data
);

  logic [DATA_W:0] sum;
  assign sum = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    resp = RESP_INV;
    data = '0;
    case (cmd)
      CMD_NOP: resp = RESP_NONE;
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          resp = RESP_OVF;
        end else begin
          resp = RESP_OK;
          data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          resp = RESP_OVF;
        end else begin
          resp = RESP_OK;
          data = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp = RESP_OK;
        data = op1 << op2[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = op1 >> op2[SHAMT_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_modport.sv
// Four independent two-cycle calculator ports (cmd+op1, then op2 -> response).
// Define CALC_SCAN_EN to chain the four op1 registers into a 128-bit scan path.
module calc_modport
  import calc_pkg::*;
(
  input  logic  c_clk,
  input  logic  reset,
  input  logic  a_clk,
  input  logic  b_clk,
  input  logic  scan_in,
  output logic  scan_out,
  calc_if.slave bus
);

  logic [NUM_PORTS-1:0][CMD_W-1:0]  req_cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data;

  state_e                           state_q [NUM_PORTS];
  state_e                           state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0][CMD_W-1:0]  cmd_q, cmd_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op1_q, op1_d;
  logic [NUM_PORTS-1:0][RESP_W-1:0] out_resp_q, out_resp_d, alu_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d, alu_data;
  logic                             scan_out_q, scan_out_d;

  assign req_cmd  = {bus.req4_cmd_in,  bus.req3_cmd_in,  bus.req2_cmd_in,  bus.req1_cmd_in};
  assign req_data = {bus.req4_data_in, bus.req3_data_in, bus.req2_data_in, bus.req1_data_in};

  assign bus.out_resp1 = out_resp_q[0];
  assign bus.out_resp2 = out_resp_q[1];
  assign bus.out_resp3 = out_resp_q[2];
  assign bus.out_resp4 = out_resp_q[3];
  assign bus.out_data1 = out_data_q[0];
  assign bus.out_data2 = out_data_q[1];
  assign bus.out_data3 = out_data_q[2];
  assign bus.out_data4 = out_data_q[3];
  assign scan_out      = scan_out_q;

  // op2 is taken straight off the bus during the OP2 cycle.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_alu
    calc_alu u_alu (
      .cmd  (cmd_q[p]),
      .op1  (op1_q[p]),
      .op2  (req_data[p]),
      .resp (alu_resp[p]),
      .data (alu_data[p])
    );
  end

`ifndef CALC_SCAN_EN
  logic unused_scan;
  assign unused_scan = a_clk ^ scan_in;
`endif

  always_comb begin
    logic scan_si;
    logic scan_next;
    scan_si    = scan_in;
    scan_next  = scan_in;
    scan_out_d = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_d[p]    = state_q[p];
      cmd_d[p]      = cmd_q[p];
      op1_d[p]      = op1_q[p];
      out_resp_d[p] = RESP_NONE;
      out_data_d[p] = '0;
      if (b_clk) begin
        out_resp_d[p] = out_resp_q[p];
        out_data_d[p] = out_data_q[p];
      end else begin
        case (state_q[p])
          ST_IDLE: begin
            if (req_cmd[p] != CMD_NOP) begin
              state_d[p] = ST_OP2;
              cmd_d[p]   = req_cmd[p];
              op1_d[p]   = req_data[p];
            end
          end
          ST_OP2: begin
            out_resp_d[p] = alu_resp[p];
            out_data_d[p] = alu_data[p];
            state_d[p]    = ST_IDLE;
          end
          default: state_d[p] = ST_IDLE;
        endcase
      end
`ifdef CALC_SCAN_EN
      // Serial data enters each register at its MSB and leaves at its LSB.
      scan_si   = scan_next;
      scan_next = op1_q[p][0];
      if (a_clk) op1_d[p] = {scan_si, op1_q[p][DATA_W-1:1]};
`endif
    end
`ifdef CALC_SCAN_EN
    scan_out_d = a_clk ? scan_next : scan_out_q;
`endif
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ST_IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
      scan_out_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      scan_out_q <= scan_out_d;
    end
  end

endmodule

// File: tb/tb_calc_modport.sv
// Scoreboard bench for calc_modport: expectations queued at op2 drive, matched at response.
module tb_calc_modport;

  logic c_clk, reset, a_clk, b_clk, scan_in, scan_out;
  int   cyc;
  int   n_vec, n_err;

  calc_if bus();

  calc_modport dut (
    .c_clk    (c_clk),
    .reset    (reset),
    .a_clk    (a_clk),
    .b_clk    (b_clk),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .bus      (bus)
  );

  typedef struct {
    int          port;
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        return (s > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  function automatic logic [1:0] get_resp(input int p);
    case (p)
      0: return bus.out_resp1;
      1: return bus.out_resp2;
      2: return bus.out_resp3;
      default: return bus.out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int p);
    case (p)
      0: return bus.out_data1;
      1: return bus.out_data2;
      2: return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] d);
    case (p)
      0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
      1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
      2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
    endcase
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push(input int p, input int at, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [33:0] m;
    m      = model(c, a, b);
    e.port = p;
    e.cyc  = at;
    e.resp = m[33:32];
    e.data = m[31:0];
    sb.push_back(e);
  endtask

  // cmd+op1, then op2 (optionally held one edge by b_clk), then idle bus
  task automatic op(input logic [3:0] mask, input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b, input bit hold = 1'b0);
    for (int p = 0; p < 4; p++) if (mask[p]) set_req(p, c, a);
    tick();
    for (int p = 0; p < 4; p++) if (mask[p]) set_req(p, 4'd0, b);
    if (hold) begin
      b_clk = 1'b1;
      tick();
      b_clk = 1'b0;
    end
    for (int p = 0; p < 4; p++) if (mask[p]) push(p, cyc + 1, c, a, b);
    tick();
    for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);
  endtask

  always @(negedge c_clk) begin
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        logic [1:0]  r;
        logic [31:0] d;
        bit          hit;
        r   = get_resp(p);
        d   = get_data(p);
        hit = 1'b0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].port == p && sb[i].cyc == cyc) begin
            chk($sformatf("p%0d_resp", p + 1), 64'(r), 64'(sb[i].resp));
            chk($sformatf("p%0d_data", p + 1), 64'(d), 64'(sb[i].data));
            sb.delete(i);
            hit = 1'b1;
            break;
          end
        end
        if (!hit && (r != 2'd0 || d != 32'd0))
          chk($sformatf("p%0d_spurious", p + 1), {30'd0, r, d}, 64'd0);
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          chk($sformatf("p%0d_missing_at_cycle", sb[i].port + 1), 64'(cyc), 64'(sb[i].cyc));
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    logic [3:0] cmds [8];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    a_clk = 1'b0;
    b_clk = 1'b0;
    scan_in = 1'b0;
    for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_resp%0d", p + 1), 64'(get_resp(p)), 64'd0);
      chk($sformatf("rst_data%0d", p + 1), 64'(get_data(p)), 64'd0);
    end
    chk("rst_scan_out", 64'(scan_out), 64'd0);
    reset = 1'b0;
    tick();

    op(4'b0001, 4'd1, 32'h0000_0005, 32'h0000_0003);
    op(4'b0010, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    op(4'b0100, 4'd2, 32'd3, 32'd5);
    op(4'b0100, 4'd2, 32'd5, 32'd5);
    op(4'b1000, 4'd5, 32'h0000_0001, 32'd31);
    op(4'b1000, 4'd6, 32'h8000_0000, 32'h0000_0024);
    op(4'b1000, 4'd5, 32'h1234_5678, 32'd0);
    op(4'b1111, 4'd1, 32'd1, 32'd1);
    op(4'b1111, 4'd4, 32'd9, 32'd9);
    op(4'b0011, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

    // a command during OP2 is dropped; the monitor flags any response it makes
    set_req(0, 4'd1, 32'd7);
    tick();
    set_req(0, 4'd2, 32'd9);
    push(0, cyc + 1, 4'd1, 32'd7, 32'd9);
    tick();
    set_req(0, 4'd0, 32'd0);
    tick();
    tick();

    // reset between cmd and op2 aborts the transaction
    set_req(1, 4'd1, 32'd10);
    tick();
    reset = 1'b1;
    set_req(1, 4'd0, 32'd20);
    tick();
    chk("rst_mid_resp2", 64'(bus.out_resp2), 64'd0);
    reset = 1'b0;
    set_req(1, 4'd0, 32'd0);
    tick();
    tick();
    op(4'b0010, 4'd1, 32'd100, 32'd23);

    repeat (20) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      b = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      op(4'($urandom_range(1, 15)), cmds[$urandom_range(0, 7)], a, b);
    end

`ifdef CALC_SCAN_EN
    begin
      logic [159:0] pat;
      pat = {$urandom, $urandom, $urandom, $urandom, $urandom};
      a_clk = 1'b1;
      for (int j = 0; j < 160; j++) begin
        scan_in = pat[j];
        tick();
        if (j >= 128) chk("scan_out", 64'(scan_out), 64'(pat[j-128]));
      end
      a_clk = 1'b0;
      scan_in = 1'b0;
    end
`else
    a_clk = 1'b1;
    scan_in = 1'b1;
    repeat (3) tick();
    chk("scan_out_tied", 64'(scan_out), 64'd0);
    a_clk = 1'b0;
    scan_in = 1'b0;
`endif
    op(4'b0101, 4'd1, 32'd40, 32'd2);

    repeat (4) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_modport.md
# calc_modport

Four-port 32-bit integer calculator. Each port takes a command plus two operands and returns a 2-bit response and a 32-bit result. It is the compute core behind the calculator bench's driver/monitor interface and sits directly between the four requester channels and the response collector. The four ports run independently and in parallel.

## Interface
Parameters:
- None. All widths are fixed: data 32, command 4, response 2.

Ports (bit 0 is the MSB, bit 31 the LSB of every 32-bit bus):
- c_clk  in  1  — sole functional clock; all state updates on its rising edge.
- reset  in  1  — asynchronous, active-high. Clears all state and outputs immediately.
- reqN_cmd_in  in  4  — command for port N (N=1..4).
- reqN_data_in  in  32  — operand bus for port N.
- out_respN  out  2  — response for port N.
- out_dataN  out  32  — result for port N.
- a_clk  in  1  — scan shift enable, sampled on c_clk.
- b_clk  in  1  — functional hold, sampled on c_clk.
- scan_in  in  1  — scan chain serial input.
- scan_out  out  1  — scan chain serial output.

## Operation
Commands:
- 0 = no-op
- 1 = add
- 2 = subtract
- 5 = shift left logical
- 6 = shift right logical
- 3, 4, 7–15 = invalid

Responses:
- 0 = none
- 1 = success
- 2 = overflow/underflow
- 3 = invalid command

Per-port FSM:
- Two states, IDLE and OP2. Reset state is IDLE.
- IDLE, cmd≠0: latch cmd and data as op1, then go to OP2.
- IDLE, cmd=0: stay in IDLE.
- OP2: the data bus is op2. Compute the result, register the response, return to IDLE.
- OP2 ignores reqN_cmd_in. A command presented in that cycle is dropped and produces no response.

Arithmetic (unsigned):
- Add: 33-bit sum. If carry out = 1, resp=2 and data=0; otherwise resp=1 and data = low 32 bits.
- Subtract: if op2 > op1, resp=2 and data=0; otherwise resp=1 and data = op1−op2.
- Shift left/right: the shift amount is op2[27:31] (0–31). Result is op1 shifted with zero fill; resp=1. Shift by 0 returns op1.
- Invalid command: consumes op2 like any other command; resp=3, data=0.

Output rules:
- out_respN/out_dataN are nonzero only in the single response cycle; they are 0 in every other cycle.
- There is no cross-port arbitration. Simultaneous commands on all four ports all complete with identical latency.

## Timing
- Reset values: all out_respN = 0, all out_dataN = 0, scan_out = 0, all FSMs in IDLE, all op1 registers 0.
- Reset asserted mid-operation aborts the transaction; no response is ever issued for it.
- Command sampled at edge k, op2 sampled at edge k+1. The response is registered at edge k+1 and is visible for the cycle k+1..k+2. At edge k+2 the outputs clear to 0.
- The next command may be presented at edge k+2, giving back-to-back throughput of one operation per 2 cycles per port.
- b_clk=1: all functional state (FSMs, op1 registers, outputs) holds its value for that edge.

## Configuration
- CALC_SCAN_EN defined:
  - The four op1 registers form a 128-bit scan chain: scan_in → port1 bit 0 … port4 bit 31 → scan_out.
  - On each edge with a_clk=1 the chain shifts by one. Shift takes priority over functional op1 updates.
  - scan_out is registered.
- CALC_SCAN_EN undefined:
  - a_clk and scan_in are ignored; scan_out is tied to 0.
  - b_clk hold still applies.

## Structure
- Package calc_pkg holds:
  - command enum: CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR
  - response enum: RESP_NONE, RESP_OK, RESP_OVF, RESP_INV
  - width constants: DATA_W = 32, CMD_W = 4
  - FSM state type
- Sub-module calc_alu: purely combinational. Takes (cmd, op1, op2) and returns (resp, data). Instantiated four times, once per port; the top level holds the FSMs, registers and scan chain.

## Test plan
- Add on port 1: cmd=1, data 0x0000_0005 then 0x0000_0003. Expect resp=1, data=0x0000_0008 exactly one cycle after op2; outputs 0 the cycle after that.
- Add overflow on port 2: 0xFFFF_FFFF + 0x0000_0001. Expect resp=2, data=0.
- Subtract on port 3: 3−5 gives resp=2, data=0. 5−5 gives resp=1, data=0.
- Shifts on port 4: shl 0x0000_0001 by 31 → resp=1, data=0x8000_0000. shr 0x8000_0000 by 0x0000_0024 (low 5 bits = 4) → resp=1, data=0x0800_0000.
- Concurrency and invalid commands: all four ports issue add 1+1 in the same cycle → four resp=1, data=2 in the same cycle. Then cmd=4 → resp=3, data=0. A cmd issued during an OP2 cycle produces no response.
- Reset asserted between cmd and op2 → no response issued. First command after reset deasserts completes normally.
